// File: rtl/ex_ls_pkg.sv
// Shared types and encodings for the load/store execution unit.
// Holds operand types, funct3 encodings, FSM states and the byte-count helper.
package ex_ls_pkg;

    localparam int REGTAG_W = 4;
    localparam int FUNCT3_W = 3;
    localparam int LS_OP_W  = 4;

    typedef logic [REGTAG_W-1:0] regtag_t;
    typedef logic [31:0]         word_t;
    typedef logic [31:0]         addr_t;
    typedef logic [4:0]          regaddr_t;
    typedef logic [FUNCT3_W-1:0] funct3_t;

    localparam funct3_t F3_B  = 3'b000;
    localparam funct3_t F3_H  = 3'b001;
    localparam funct3_t F3_W  = 3'b010;
    localparam funct3_t F3_BU = 3'b100;
    localparam funct3_t F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_XFER = 3'd2,
        ST_CAPT = 3'd3,
        ST_WB   = 3'd4
    } ls_state_t;

    // Index of the final byte of an access (N-1); reserved size code treated as word.
    function automatic logic [1:0] last_index(input funct3_t f3);
        logic [1:0] idx;
        case (f3[1:0])
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ex_ls_extend.sv
// Load result extension: sign-extends B/H, zero-extends BU/HU, passes W through.
module ex_ls_extend
    import ex_ls_pkg::*;
(
    input  word_t   raw,
    input  funct3_t funct3,
    output word_t   ext
);

    // Select extension by access type
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            F3_W:    ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/ex_ls.sv
// Load/store unit: serialises one memory op into byte transfers on a shared
// byte-wide port and broadcasts load results on the third writeback slot.
module ex_ls
    import ex_ls_pkg::*;
#(
    parameter int TAG_W = REGTAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               ls_en_in,
    input  logic [LS_OP_W-1:0] ls_op_in,
    input  word_t              ls_base_in,
    input  word_t              ls_offset_in,
    input  word_t              ls_data_in,
    input  logic [TAG_W-1:0]   ls_tagw_in,
    input  regaddr_t           ls_target_in,
    output logic               busy_out,
    output logic               mem_req_out,
    input  logic               mem_gnt_in,
    output addr_t              mem_addr_out,
    output logic               mem_wr_out,
    output logic [7:0]         mem_dout,
    input  logic [7:0]         mem_din,
    output logic               wb_en_out,
    output regaddr_t           wb_target_out,
    output word_t              wb_data_out,
    output logic [TAG_W-1:0]   wb_tag_out
);

    ls_state_t        state_r;
    ls_state_t        state_nx_s;
    logic             is_store_r;
    funct3_t          funct3_r;
    addr_t            addr_r;
    word_t            data_r;
    logic [TAG_W-1:0] tag_r;
    regaddr_t         target_r;
    logic [1:0]       k_r;
    logic [1:0]       last_k_r;
    word_t            result_r;
    logic             cap_pend_r;
    logic [1:0]       cap_idx_r;

    logic             accept_s;
    logic             issue_s;
    logic             last_s;
    logic [7:0]       byte_k_s;
    word_t            ext_s;

    assign accept_s = (state_r == ST_IDLE) && ls_en_in && rdy;
    // A byte counts as issued only when the cycle is active and the bus is ours.
    assign issue_s  = (state_r == ST_XFER) && rdy && mem_gnt_in;
    assign last_s   = (k_r == last_k_r);

    ex_ls_extend u_extend (
        .raw    (result_r),
        .funct3 (funct3_r),
        .ext    (ext_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand latch at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            addr_r     <= 32'd0;
            data_r     <= 32'd0;
            tag_r      <= '0;
            target_r   <= 5'd0;
            last_k_r   <= 2'd0;
        end else if (accept_s) begin
            is_store_r <= ls_op_in[3];
            funct3_r   <= ls_op_in[2:0];
            addr_r     <= ls_base_in + ls_offset_in;
            data_r     <= ls_data_in;
            tag_r      <= ls_tagw_in;
            target_r   <= ls_target_in;
            last_k_r   <= last_index(ls_op_in[2:0]);
        end
    end

    // Byte index and read capture; a pending capture completes even while rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r        <= 2'd0;
            cap_pend_r <= 1'b0;
            cap_idx_r  <= 2'd0;
            result_r   <= 32'd0;
        end else begin
            if (accept_s) begin
                k_r <= 2'd0;
            end else if (issue_s) begin
                k_r <= k_r + 2'd1;
            end
            cap_pend_r <= issue_s && !is_store_r;
            if (issue_s) begin
                cap_idx_r <= k_r;
            end
            if (accept_s) begin
                result_r <= 32'd0;
            end else if (cap_pend_r) begin
                case (cap_idx_r)
                    2'd0:    result_r[7:0]   <= mem_din;
                    2'd1:    result_r[15:8]  <= mem_din;
                    2'd2:    result_r[23:16] <= mem_din;
                    default: result_r[31:24] <= mem_din;
                endcase
            end
        end
    end

    // Little-endian store byte selection
    always_comb begin
        byte_k_s = 8'd0;
        case (k_r)
            2'd0:    byte_k_s = data_r[7:0];
            2'd1:    byte_k_s = data_r[15:8];
            2'd2:    byte_k_s = data_r[23:16];
            default: byte_k_s = data_r[31:24];
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_nx_s    = state_r;
        busy_out      = 1'b0;
        mem_req_out   = 1'b0;
        mem_addr_out  = 32'd0;
        mem_wr_out    = 1'b0;
        mem_dout      = 8'd0;
        wb_en_out     = 1'b0;
        wb_target_out = 5'd0;
        wb_data_out   = 32'd0;
        wb_tag_out    = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_ARB;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                busy_out    = 1'b1;
                mem_req_out = 1'b1;
                if (rdy && mem_gnt_in) begin
                    state_nx_s = ST_XFER;
                end else begin
                    state_nx_s = ST_ARB;
                end
            end
            ST_XFER: begin
                busy_out     = 1'b1;
                mem_req_out  = 1'b1;
                mem_addr_out = addr_r + {30'd0, k_r};
                mem_wr_out   = issue_s && is_store_r;
                if (is_store_r) begin
                    mem_dout = byte_k_s;
                end else begin
                    mem_dout = 8'd0;
                end
                if (issue_s && last_s) begin
                    if (is_store_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_CAPT;
                    end
                end else begin
                    state_nx_s = ST_XFER;
                end
            end
            ST_CAPT: begin
                busy_out = 1'b1;
                if (rdy) begin
                    state_nx_s = ST_WB;
                end else begin
                    state_nx_s = ST_CAPT;
                end
            end
            ST_WB: begin
                busy_out      = 1'b1;
                // x0 loads still occupy WB but never release a tag
                wb_en_out     = rdy && (target_r != 5'd0);
                wb_target_out = target_r;
                wb_data_out   = ext_s;
                wb_tag_out    = tag_r;
                if (rdy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_ls.sv
// Bench for ex_ls: table of single ops plus stall/grant/reset sequences,
// with a byte-wide memory model and scoreboards for writes and writebacks.
module tb_ex_ls;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ls_en_in = 1'b0;
    logic [3:0]  ls_op_in = 4'd0;
    logic [31:0] ls_base_in = 32'd0;
    logic [31:0] ls_offset_in = 32'd0;
    logic [31:0] ls_data_in = 32'd0;
    logic [3:0]  ls_tagw_in = 4'd0;
    logic [4:0]  ls_target_in = 5'd0;
    logic        busy_out;
    logic        mem_req_out;
    logic        mem_gnt_in = 1'b1;
    logic [31:0] mem_addr_out;
    logic        mem_wr_out;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'd0;
    logic        wb_en_out;
    logic [4:0]  wb_target_out;
    logic [31:0] wb_data_out;
    logic [3:0]  wb_tag_out;

    always #5 clk = ~clk;

    ex_ls #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ls_en_in(ls_en_in), .ls_op_in(ls_op_in), .ls_base_in(ls_base_in),
        .ls_offset_in(ls_offset_in), .ls_data_in(ls_data_in),
        .ls_tagw_in(ls_tagw_in), .ls_target_in(ls_target_in),
        .busy_out(busy_out), .mem_req_out(mem_req_out), .mem_gnt_in(mem_gnt_in),
        .mem_addr_out(mem_addr_out), .mem_wr_out(mem_wr_out), .mem_dout(mem_dout),
        .mem_din(mem_din), .wb_en_out(wb_en_out), .wb_target_out(wb_target_out),
        .wb_data_out(wb_data_out), .wb_tag_out(wb_tag_out)
    );

    // Read-only memory model: data for an address appears the cycle after it.
    logic [7:0] mem [0:65535];
    logic [7:0] nxt_din = 8'd0;
    always @(negedge clk) nxt_din = mem[mem_addr_out[15:0]];
    always @(posedge clk) begin
        #1;
        mem_din = nxt_din;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;
    typedef struct packed {
        logic [4:0]  tgt;
        logic [3:0]  tag;
        logic [31:0] data;
    } wb_t;
    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] data;
        logic [4:0]  tgt;
        logic [3:0]  tag;
        logic [31:0] bytes;
        logic [31:0] exp_wb;
        logic [3:0]  busy;
    } vec_t;

    wr_t  wr_q [$];
    wb_t  wb_q [$];
    vec_t vt [12];
    logic [31:0] ea [7];
    logic        ew [7];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic [31:0] data, input logic [4:0] tgt,
                                input logic [3:0] tag, input logic [31:0] bytes,
                                input logic [31:0] exp_wb, input logic [3:0] busy);
        vec_t v;
        v.st = st; v.f3 = f3; v.base = base; v.off = off; v.data = data;
        v.tgt = tgt; v.tag = tag; v.bytes = bytes; v.exp_wb = exp_wb; v.busy = busy;
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] bytes);
        logic [31:0] aj;
        for (int j = 0; j < 4; j++) begin
            aj = a + 32'(j);
            mem[aj[15:0]] = bytes[8*j +: 8];
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] data,
                         input logic [4:0] tgt, input logic [3:0] tag,
                         input logic [31:0] exp_wb);
        logic [31:0] a;
        wr_t w;
        wb_t b;
        int n;
        a = base + off;
        n = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        if (st) begin
            for (int j = 0; j < n; j++) begin
                w.addr = a + 32'(j);
                w.data = data[8*j +: 8];
                wr_q.push_back(w);
            end
        end else if (tgt != 5'd0) begin
            b.tgt = tgt; b.tag = tag; b.data = exp_wb;
            wb_q.push_back(b);
        end
        ls_op_in = {st, f3}; ls_base_in = base; ls_offset_in = off;
        ls_data_in = data; ls_target_in = tgt; ls_tagw_in = tag;
        ls_en_in = 1'b1;
        @(posedge clk);
        #1;
        ls_en_in = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (!busy_out) break;
            cyc++;
        end
        if (busy_out) chk("idle_timeout", {31'd0, busy_out}, 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
        chk({tag, "_req"},  {31'd0, mem_req_out}, 32'd0);
        chk({tag, "_wr"},   {31'd0, mem_wr_out}, 32'd0);
        chk({tag, "_addr"}, mem_addr_out, 32'd0);
        chk({tag, "_dout"}, {24'd0, mem_dout}, 32'd0);
        chk({tag, "_wben"}, {31'd0, wb_en_out}, 32'd0);
        chk({tag, "_wbdata"}, wb_data_out, 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Writeback and store-byte scoreboard monitor
        fork
            begin : monitor
                wb_t e;
                wr_t w;
                forever begin
                    @(negedge clk);
                    if (wb_en_out) begin
                        if (wb_q.size() == 0) begin
                            chk("wb_unexpected", {31'd0, wb_en_out}, 32'd0);
                        end else begin
                            e = wb_q.pop_front();
                            chk("wb_data", wb_data_out, e.data);
                            chk("wb_tgt_tag", {23'd0, wb_target_out, wb_tag_out},
                                {23'd0, e.tgt, e.tag});
                        end
                    end
                    if (mem_wr_out) begin
                        if (wr_q.size() == 0) begin
                            chk("wr_unexpected", {31'd0, mem_wr_out}, 32'd0);
                        end else begin
                            w = wr_q.pop_front();
                            chk("wr_addr", mem_addr_out, w.addr);
                            chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
                        end
                    end
                end
            end
        join_none

        vt[0]  = mk(1'b0, 3'b010, 32'h0000_00F0, 32'h0000_0010, 32'd0, 5'd5,  4'd3,  32'h1234_5678, 32'h1234_5678, 4'd7);
        vt[1]  = mk(1'b0, 3'b000, 32'h0000_0310, 32'hFFFF_FFF0, 32'd0, 5'd6,  4'd4,  32'h0000_0080, 32'hFFFF_FF80, 4'd4);
        vt[2]  = mk(1'b0, 3'b100, 32'h0000_0300, 32'h0000_0000, 32'd0, 5'd7,  4'd5,  32'h0000_0080, 32'h0000_0080, 4'd4);
        vt[3]  = mk(1'b0, 3'b001, 32'h0000_8000, 32'h0000_0001, 32'd0, 5'd8,  4'd6,  32'h0000_8001, 32'hFFFF_8001, 4'd5);
        vt[4]  = mk(1'b0, 3'b101, 32'h0000_8001, 32'h0000_0000, 32'd0, 5'd9,  4'd7,  32'h0000_8001, 32'h0000_8001, 4'd5);
        vt[5]  = mk(1'b0, 3'b010, 32'h0000_0400, 32'h0000_0003, 32'd0, 5'd10, 4'd8,  32'h4433_2211, 32'h4433_2211, 4'd7);
        vt[6]  = mk(1'b1, 3'b010, 32'h0000_0500, 32'h0000_0000, 32'hCAFE_BABE, 5'd0, 4'd0, 32'd0, 32'd0, 4'd5);
        vt[7]  = mk(1'b1, 3'b001, 32'h0000_0201, 32'h0000_0000, 32'hAABB_CCDD, 5'd0, 4'd0, 32'd0, 32'd0, 4'd3);
        vt[8]  = mk(1'b1, 3'b000, 32'h0000_05FF, 32'h0000_0001, 32'h1234_565A, 5'd0, 4'd0, 32'd0, 32'd0, 4'd2);
        vt[9]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000, 32'd0, 5'd0,  4'd9,  32'hDEAD_BEEF, 32'd0, 4'd7);
        vt[10] = mk(1'b0, 3'b001, 32'hFFFF_FF00, 32'h0000_00FE, 32'd0, 5'd12, 4'd10, 32'h0000_9234, 32'hFFFF_9234, 4'd5);
        vt[11] = mk(1'b0, 3'b000, 32'h0000_0700, 32'h0000_0000, 32'd0, 5'd31, 4'd15, 32'h0000_007F, 32'h0000_007F, 4'd4);

        for (int i = 0; i < 12; i++) begin
            if (!vt[i].st) preload(vt[i].base + vt[i].off, vt[i].bytes);
            issue(vt[i].st, vt[i].f3, vt[i].base, vt[i].off, vt[i].data,
                  vt[i].tgt, vt[i].tag, vt[i].exp_wb);
            wait_idle(cyc);
            chk($sformatf("row%0d_busy_cycles", i), 32'(cyc), {28'd0, vt[i].busy});
        end

        // LW cycle-by-cycle: addresses in cycles 2..5, writeback pulse in cycle 7
        preload(32'h0000_0100, 32'h1234_5678);
        ea = '{32'h0, 32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
        ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 5'd13, 4'd11, 32'h1234_5678);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("lw_cyc%0d_addr", c + 1), mem_addr_out, ea[c]);
            chk($sformatf("lw_cyc%0d_wben", c + 1), {31'd0, wb_en_out}, {31'd0, ew[c]});
        end
        @(negedge clk);
        chk("lw_idle_cyc8", {31'd0, busy_out}, 32'd0);

        // Grant delayed 3 cycles, then rdy low 2 cycles mid-LW
        preload(32'h0000_0C00, 32'hA1B2_C3D4);
        mem_gnt_in = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0C00, 32'h0, 32'h0, 5'd14, 4'd12, 32'hA1B2_C3D4);
        repeat (3) @(posedge clk);
        #1 mem_gnt_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
        wait_idle(cyc);
        chk("stall_lw_remaining_busy", 32'(cyc), 32'd5);

        // rdy low while in WB: pulse deferred to the next active cycle
        preload(32'h0000_0900, 32'h0000_00F0);
        issue(1'b0, 3'b000, 32'h0000_0900, 32'h0, 32'h0, 5'd15, 4'd13, 32'hFFFF_FFF0);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
        wait_idle(cyc);
        chk("wb_stall_remaining_busy", 32'(cyc), 32'd1);

        // Grant dropped for 2 cycles mid-SW
        issue(1'b1, 3'b010, 32'h0000_0A00, 32'h0, 32'h0102_0304, 5'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 mem_gnt_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_gnt_in = 1'b1;
        wait_idle(cyc);
        chk("gnt_loss_remaining_busy", 32'(cyc), 32'd3);

        // Reset during SW transfer: byte 0 written, nothing afterwards
        issue(1'b1, 3'b010, 32'h0000_0B00, 32'h0, 32'h1122_3344, 5'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        chk("midreset_pending_writes", 32'(wr_q.size()), 32'd3);
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset_busy%0d", c), {31'd0, busy_out}, 32'd0);
        end

        repeat (2) @(negedge clk);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_ls.md
# ex_ls

Load/store execution unit. It sits beside the two ALU execution stages, downstream of the allocator / reservation-station issue path. It accepts one memory operation at a time and serialises it into byte transfers on a shared byte-wide memory port, with a request/grant handshake to the memory arbiter. Load results are broadcast on the third register-write / tag-broadcast slot, so reg_stat and the reservation stations can unlock the destination register.

## Interface
- TAG_W, 4: width of register-status tag; must equal `regtag_t` width.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes the block.
- ls_en_in  in  1  issue strobe, qualified with busy_out=0.
- ls_op_in  in  4  {is_store, funct3}; funct3 follows RV32I (000 B, 001 H, 010 W, 100 BU, 101 HU).
- ls_base_in  in  32  base register value (rs1).
- ls_offset_in  in  32  sign-extended immediate.
- ls_data_in  in  32  store data (rs2); ignored for loads.
- ls_tagw_in  in  TAG_W  tag broadcast with load result.
- ls_target_in  in  5  load destination register.
- busy_out  out  1  high in every state except IDLE.
- mem_req_out  out  1  bus request to arbiter.
- mem_gnt_in  in  1  bus grant from arbiter.
- mem_addr_out  out  32  byte address.
- mem_wr_out  out  1  1 = write.
- mem_dout  out  8  write byte.
- mem_din  in  8  read byte, valid one cycle after its address.
- wb_en_out  out  1  one-cycle load writeback pulse.
- wb_target_out  out  5  destination register.
- wb_data_out  out  32  extended load value.
- wb_tag_out  out  TAG_W  tag being released.

## Operation
- **Address and length**
  - Effective address A = ls_base_in + ls_offset_in, mod 2^32, computed at accept.
  - Byte count N = 1, 2 or 4 from funct3[1:0].
  - Misaligned addresses are legal because every byte is issued individually.
- **States:** IDLE → ARB → XFER → (loads) CAPT → WB → IDLE; stores go XFER → IDLE.
- **IDLE:** on ls_en_in=1 and rdy=1, latch the op, A, data, tag and target; go to ARB.
- **ARB**
  - mem_req_out=1.
  - When mem_gnt_in=1, go to XFER with byte index k=0.
- **XFER**
  - mem_req_out=1; mem_addr_out = A+k.
  - Stores: mem_wr_out=1, mem_dout = data byte k (little-endian).
  - Loads: mem_wr_out=0. The byte for address k is captured on the edge ending the next active cycle into result byte k.
  - k increments each active cycle. After byte N-1, stores go to IDLE and loads go to CAPT.
- **CAPT**
  - Captures the last byte; mem_req_out=0; mem_addr_out=0.
- **WB**
  - wb_en_out=1; wb_data_out = result sign-extended (B, H) or zero-extended (BU, HU, W).
  - wb_target_out and wb_tag_out are the latched values.
  - Then go to IDLE.
- **Outside XFER:** mem_wr_out=0, mem_addr_out=0, mem_dout=0.
- **ls_en_in while busy_out=1:** ignored; the allocator must not do this.
- **Load to x0:** bus transfer is performed in full; wb_en_out stays 0 in WB.
- **Grant loss:** mem_gnt_in low during XFER is an arbiter fault. The block holds k, forces mem_wr_out=0, and resumes when the grant returns.
- **rdy=0:**
  - State, k and all latched values hold; mem_wr_out is forced 0.
  - A read byte whose address was issued in the preceding active cycle is still captured, via a pending-capture flag, so no data is lost.
  - wb_en_out is gated to 0, and the WB pulse is presented in the next rdy=1 cycle.
- **Reset (any state, including mid-transfer):** state IDLE, k=0, all outputs 0, no writeback.

## Timing
- Accept on edge E0.
- ARB occupies cycle 1, or longer until grant.
- With grant in cycle 1, XFER occupies cycles 2 .. N+1.
- Store: busy_out falls in cycle N+2.
- Load: CAPT in cycle N+2, WB pulse in cycle N+3, IDLE in cycle N+4.
- Minimum occupancy: LW 7 cycles and SW 5 cycles, from the first busy cycle through the last busy cycle.
- Each extra cycle without grant or with rdy=0 adds one cycle.
- Back-to-back: a new op is accepted on the edge that ends the first IDLE cycle.

## Structure
- cpu_defs.vh holds:
  - LS op encodings and the funct3 width constants.
  - `regtag_t` / TAG_W, `word_t`, `addr_t`, `regaddr_t`.
  - State encodings for IDLE, ARB, XFER, CAPT, WB.
- Sub-module ls_extend: combinational, takes the 32-bit raw result and funct3, and produces the extended value. It is instantiated once for wb_data_out.

## Test plan
- **LW:** A=0x100, memory bytes 78 56 34 12, grant held → addresses 0x100..0x103 in cycles 2-5; wb_data_out=0x12345678 and wb_en_out=1 in cycle 7.
- **LB vs LBU:** byte 0x80 → LB gives 0xFFFFFF80; LBU gives 0x00000080. LH on 0x8001 gives 0xFFFF8001.
- **SH misaligned:** base 0x201, offset 0, data 0xAABBCCDD → writes 0xDD@0x201 and 0xCC@0x202 with mem_wr_out=1; no wb_en_out; busy_out falls in cycle 4.
- **Delayed grant / rdy stall:** grant delayed 3 cycles, then rdy=0 for 2 cycles mid-LW → no byte skipped or duplicated; mem_wr_out stays 0 throughout; result still correct.
- **Reset and x0:** reset asserted during XFER of SW → all outputs 0 immediately, no further writes. LW to x0 → 4 reads occur, wb_en_out never asserts.
